// File: rtl/snn_pkg.sv
// snn_pkg: shared LIF neuron types, Q-format constant and saturation helper.
package snn_pkg;

    typedef enum logic [1:0] {INTEG, FIRE, REFRAC} lif_state_t;

    localparam int FRAC_W = 7;

    function automatic logic signed [63:0] sat(input logic signed [63:0] x, input int w);
        logic signed [63:0] hi, lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        return x > hi ? hi : x < lo ? lo : x;
    endfunction

endpackage

// File: rtl/lif_neuron_if.sv
// lif_neuron_if: input handshake plus neuron status outputs.
interface lif_neuron_if #(
    parameter int IN_W  = 8,
    parameter int MEM_W = 12
);
    logic                    in_valid;
    logic                    in_ready;
    logic signed [IN_W-1:0]  in_sum;
    logic signed [MEM_W-1:0] threshold;
    logic                    spike_out;
    logic signed [MEM_W-1:0] mem_pot;
    logic                    refrac;

    modport master (output in_valid, in_sum, threshold, input in_ready, spike_out, mem_pot, refrac);
    modport slave  (input in_valid, in_sum, threshold, output in_ready, spike_out, mem_pot, refrac);
endinterface

// File: rtl/lif_sat_add.sv
// lif_sat_add: widened leak-and-integrate add with clamp; leak compiled in when LIF_LEAK_EN is defined.
module lif_sat_add
    import snn_pkg::*;
#(
    parameter int IN_W       = 8,
    parameter int MEM_W      = 12,
    parameter int LEAK_SHIFT = 3
) (
    input  logic signed [IN_W-1:0]  in_sum_i,
    input  logic signed [MEM_W-1:0] v_i,
    output logic signed [MEM_W-1:0] sum_o
);
`ifdef LIF_LEAK_EN
    localparam bit LEAK_ON = 1'b1;
`else
    localparam bit LEAK_ON = 1'b0;
`endif
    logic signed [MEM_W+1:0] v_w, shr_w, leak_w, in_w, sum_w;

    assign v_w    = (MEM_W+2)'(v_i);
    assign in_w   = (MEM_W+2)'(in_sum_i);
    assign shr_w  = v_w >>> LEAK_SHIFT;
    assign leak_w = LEAK_ON ? shr_w : '0;
    assign sum_w  = v_w - leak_w + in_w;
    assign sum_o  = MEM_W'(sat(64'(sum_w), MEM_W));
endmodule

// File: rtl/lif_neuron.sv
// lif_neuron: leaky integrate-and-fire neuron with refractory period; leak enabled by LIF_LEAK_EN.
module lif_neuron
    import snn_pkg::*;
#(
    parameter int IN_W       = 8,
    parameter int MEM_W      = 12,
    parameter int REFRAC_CYC = 4,
    parameter int LEAK_SHIFT = 3
) (
    input logic         clk,
    input logic         rst,
    lif_neuron_if.slave bus
);
    localparam int CW = REFRAC_CYC > 0 ? $clog2(REFRAC_CYC + 1) : 1;

    lif_state_t              state_q;
    logic signed [MEM_W-1:0] v_q, v_d;
    logic [CW-1:0]           cnt_q;
    logic                    spike_q, refrac_q, ready_q;
    logic                    xfer;

    assign xfer          = bus.in_valid && ready_q;
    assign bus.in_ready  = ready_q;
    assign bus.spike_out = spike_q;
    assign bus.refrac    = refrac_q;
    assign bus.mem_pot   = v_q;

    lif_sat_add #(.IN_W(IN_W), .MEM_W(MEM_W), .LEAK_SHIFT(LEAK_SHIFT)) u_add (
        .in_sum_i (bus.in_sum),
        .v_i      (v_q),
        .sum_o    (v_d)
    );

    // Integrate on transfer, fire for one cycle, then hold off input for the refractory count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= INTEG;
            v_q      <= '0;
            cnt_q    <= '0;
            spike_q  <= 1'b0;
            refrac_q <= 1'b0;
            ready_q  <= 1'b1;
        end else begin
            case (state_q)
                INTEG: if (xfer) begin
                    v_q <= v_d;
                    if (v_d >= bus.threshold) begin
                        state_q  <= FIRE;
                        spike_q  <= 1'b1;
                        refrac_q <= 1'b1;
                        ready_q  <= 1'b0;
                    end
                end
                FIRE: begin
                    spike_q <= 1'b0;
                    v_q     <= '0;
                    if (REFRAC_CYC == 0) begin
                        state_q  <= INTEG;
                        refrac_q <= 1'b0;
                        ready_q  <= 1'b1;
                    end else begin
                        state_q <= REFRAC;
                        cnt_q   <= CW'(REFRAC_CYC);
                    end
                end
                REFRAC: if (cnt_q == CW'(1)) begin
                    state_q  <= INTEG;
                    cnt_q    <= '0;
                    refrac_q <= 1'b0;
                    ready_q  <= 1'b1;
                end else begin
                    cnt_q <= cnt_q - CW'(1);
                end
                default: state_q <= INTEG;
            endcase
        end
    end
endmodule
